// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants, the fetch buffer entry type and a small
//                address helper for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8002_0000;
   localparam logic [1:0]  ACCESS_WORD       = 2'b00;
   localparam int          INSN_W            = 32;

   // One buffered fetch: the instruction word and the PC it came from.
   typedef struct packed {
      logic [INSN_W-1:0] insn;
      logic [31:0]       pc;
   } fetch_entry_t;

   // Force an address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of fetch entries with flush and an
//                occupancy count. The head entry is presented combinationally.
//                Pop on empty is ignored; push when full is only accepted if
//                a pop happens in the same cycle. Flush wins over push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = AW + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

   // Pointer and occupancy bookkeeping; flush empties the buffer at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clock) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign empty = (r_count == '0);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues one word read
//                per cycle under a credit rule that reserves a buffer slot
//                for every outstanding read, captures returned words into a
//                small FIFO and hands {insn, pc} to decode with valid/stall.
//                A branch redirect squashes buffered and in-flight fetches.
//  Config      : FETCH_PERF_EN - adds perf_issued / perf_squashed counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        do_branch,
   input  logic [31:0] branch_target,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_access_size,
   output logic        mem_dm_byte,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic [31:0] mem_data_out,
   output logic [31:0] insn_out,
   output logic [31:0] pc_out,
   output logic        insn_valid,
   output logic        misalign
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_squashed
`endif
);

   localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
   localparam int SW = CW + 1;

   logic [31:0]  r_pc;
   logic [31:0]  r_pend_pc;
   logic         r_pending;
   logic         r_active;
   logic         r_misalign;

   logic         w_deq;
   logic         w_issue;
   logic         w_push;
   logic         w_pop;
   logic [SW-1:0] w_credit;
   logic [CW-1:0] w_count;
   logic         w_empty;
   fetch_entry_t w_head;
   fetch_entry_t w_push_data;

   // Slots already promised: buffered entries plus the read in flight,
   // minus the entry decode is taking this cycle.
   assign w_deq    = insn_valid && !stall;
   assign w_credit = SW'(w_count) + SW'(r_pending) - SW'(w_deq);

   // r_active holds off issue until the first edge after reset release so
   // that mem_enable is low throughout reset.
   assign w_issue = r_active && !do_branch && (w_credit < SW'(FIFO_DEPTH));

   // A redirect discards the returning word and the head being popped.
   assign w_push = r_pending && !do_branch;
   assign w_pop  = w_deq && !do_branch;

   assign w_push_data.insn = mem_data_out;
   assign w_push_data.pc   = r_pend_pc;

   // PC, outstanding-read tracking, redirect and misalign pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_active   <= 1'b0;
         r_pc       <= BASE_ADDR;
         r_pend_pc  <= '0;
         r_pending  <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_active   <= 1'b1;
         r_misalign <= do_branch && (branch_target[1:0] != 2'b00);
         if (do_branch) begin
            r_pc      <= align_word(branch_target);
            r_pending <= 1'b0;
         end else begin
            r_pending <= w_issue;
            if (w_issue) begin
               r_pc      <= r_pc + 32'd4;
               r_pend_pc <= r_pc;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (do_branch),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count),
      .empty     (w_empty)
   );

   assign mem_address     = r_pc;
   assign mem_access_size = ACCESS_WORD;
   assign mem_dm_byte     = 1'b0;
   assign mem_rw          = 1'b1;
   assign mem_enable      = w_issue;

   // Outputs read as zero whenever the buffer is empty.
   assign insn_valid = !w_empty;
   assign insn_out   = insn_valid ? w_head.insn : '0;
   assign pc_out     = insn_valid ? w_head.pc   : '0;
   assign misalign   = r_misalign;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_squashed;

   // Issue count and squash count (flushed entries plus a dropped return).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_issued   <= '0;
         r_perf_squashed <= '0;
      end else begin
         if (w_issue) r_perf_issued <= r_perf_issued + 32'd1;
         if (do_branch) begin
            r_perf_squashed <= r_perf_squashed + 32'(w_count) + 32'(r_pending);
         end
      end
   end

   assign perf_issued   = r_perf_issued;
   assign perf_squashed = r_perf_squashed;
`endif

endmodule : fetch_unit
`default_nettype wire
